// File: rtl/shift_sequencer_4.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_4
// Purpose  : Load / shift / hold sequencer driving the mode selects, parallel
//            value and serial fills of a 4-bit universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer_4 #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             fill_i,
  input  logic [3:0]       data_in_i,
  input  logic [3:0]       a_par_i,
  output logic             s1_o,
  output logic             s0_o,
  output logic [3:0]       i_par_o,
  output logic             msb_in_o,
  output logic             lsb_in_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic [3:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // State and latched-request registers; clear aborts any sequence at once.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      data_q  <= 4'd0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; request fields are captured only when leaving IDLE.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dir_d   = dir_i;
          fill_d  = fill_i;
          data_d  = data_in_i;
          cnt_d   = count_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rem_d   = cnt_q;
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        rem_d = rem_q - CNT_W'(1);
        // The cycle with one shift remaining is the last SHIFT cycle.
        if (rem_q <= CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register-facing outputs decoded from the registered state only.
  always_comb begin
    s1_o        = 1'b0;
    s0_o        = 1'b0;
    msb_in_o    = 1'b0;
    lsb_in_o    = 1'b0;
    ser_valid_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        s1_o   = 1'b1;
        s0_o   = 1'b1;
        busy_o = 1'b1;
      end
      ST_SHIFT: begin
        s1_o        = dir_q;
        s0_o        = ~dir_q;
        msb_in_o    = ~dir_q & fill_q;
        lsb_in_o    = dir_q & fill_q;
        ser_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      ST_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // The parallel value always mirrors the latched nibble.
  assign i_par_o   = data_q;
  // Bit about to fall off the register end selected by the latched direction.
  assign ser_out_o = dir_q ? a_par_i[3] : a_par_i[0];

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer_4
// Purpose  : Self-checking bench for shift_sequencer_4 with a behavioural
//            4-bit universal shift register closing the a_par loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer_4;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] count = 3'd0;
  logic       fill = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic [3:0] a_par = 4'd0;
  logic       s1, s0, msb_in, lsb_in, ser_out, ser_valid, busy, done;
  logic [3:0] i_par;

  int tests = 0;
  int fails = 0;

  shift_sequencer_4 #(.CNT_W(3)) dut (
    .clk_i(clk), .clear_i(clear), .start_i(start), .dir_i(dir),
    .count_i(count), .fill_i(fill), .data_in_i(data_in), .a_par_i(a_par),
    .s1_o(s1), .s0_o(s0), .i_par_o(i_par), .msb_in_o(msb_in),
    .lsb_in_o(lsb_in), .ser_out_o(ser_out), .ser_valid_o(ser_valid),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register (not reset by clear).
  always @(posedge clk) begin
    case ({s1, s0})
      2'b01:   a_par <= {msb_in, a_par[3:1]};
      2'b10:   a_par <= {a_par[2:0], lsb_in};
      2'b11:   a_par <= i_par;
      default: a_par <= a_par;
    endcase
  end

  // k-th bit leaving the register: the nibble's bits in exit order, then fill.
  function automatic logic exp_ser(input logic [3:0] d, input logic dr,
                                   input logic f, input int k);
    if (k >= 4) return f;
    return dr ? d[3-k] : d[k];
  endfunction

  // Register contents after k shifts of d in direction dr with fill f.
  function automatic logic [3:0] exp_apar(input logic [3:0] d, input logic dr,
                                          input logic f, input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int src;
      src = dr ? (i - k) : (i + k);
      r[i] = (src >= 0 && src < 4) ? d[src] : f;
    end
    return r;
  endfunction

  task automatic scramble_inputs();
    dir     = 1'($urandom_range(0, 1));
    count   = 3'($urandom_range(0, 7));
    fill    = 1'($urandom_range(0, 1));
    data_in = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({s1, s0, i_par, msb_in, lsb_in, busy, done, ser_valid} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0", {s1, s0, i_par, msb_in, lsb_in, busy, done, ser_valid});
    end
    clear = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, s1, s0, i_par} !== 8'd0) begin
      fails++;
      $display("FAIL reset_idle: got %b expected 0", {busy, done, s1, s0, i_par});
    end
  endtask

  // Runs one sequence, scrambling inputs mid-run; optional start poke at idx 1.
  task automatic run_seq(input string nm, input logic [3:0] d, input logic dr,
                         input logic [2:0] c, input logic f, input bit poke);
    int  done_cnt, done_idx, busy_cnt, nser;
    bit  finished;
    @(negedge clk);
    start = 1'b1; dir = dr; count = c; fill = f; data_in = d;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; done_idx = -1; busy_cnt = 0; nser = 0; finished = 1'b0;
    for (int idx = 0; idx < 24 && !finished; idx++) begin
      if (idx > 0) @(negedge clk);
      if (idx == 0) begin
        tests++;
        if ({s1, s0} !== 2'b11 || i_par !== d || busy !== 1'b1) begin
          fails++;
          $display("FAIL %s load: s1s0=%b i_par=%b busy=%b expected 11/%b/1", nm, {s1, s0}, i_par, busy, d);
        end
      end
      if (busy === 1'b1) busy_cnt++;
      else if (idx > 0) finished = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        done_idx = idx;
      end
      if (ser_valid === 1'b1) begin
        tests++;
        if (ser_out !== exp_ser(d, dr, f, nser) || {s1, s0} !== (dr ? 2'b10 : 2'b01) ||
            msb_in !== (dr ? 1'b0 : f) || lsb_in !== (dr ? f : 1'b0)) begin
          fails++;
          $display("FAIL %s shift%0d: ser=%b s1s0=%b msb=%b lsb=%b expected ser=%b", nm, nser,
                   ser_out, {s1, s0}, msb_in, lsb_in, exp_ser(d, dr, f, nser));
        end
        nser++;
      end
      start = (poke && idx == 1);
      scramble_inputs();
    end
    start = 1'b0;
    tests++;
    if (!finished) begin
      fails++;
      $display("FAIL %s timeout: busy never dropped, expected idle after %0d cycles", nm, c + 2);
    end
    tests++;
    if (busy_cnt != c + 2 || done_cnt != 1 || done_idx != c + 1 || nser != c) begin
      fails++;
      $display("FAIL %s timing: busy=%0d done_pulses=%0d done_at=%0d shifts=%0d expected %0d/1/%0d/%0d",
               nm, busy_cnt, done_cnt, done_idx, nser, c + 2, c + 1, c);
    end
    tests++;
    if (a_par !== exp_apar(d, dr, f, int'(c)) || {s1, s0, msb_in, lsb_in} !== 4'd0) begin
      fails++;
      $display("FAIL %s final: a_par=%b ctl=%b expected %b/0000", nm, a_par, {s1, s0, msb_in, lsb_in},
               exp_apar(d, dr, f, int'(c)));
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || a_par !== exp_apar(d, dr, f, int'(c))) begin
      fails++;
      $display("FAIL %s stay_idle: busy=%b done=%b a_par=%b expected 0/0/%b", nm, busy, done, a_par,
               exp_apar(d, dr, f, int'(c)));
    end
  endtask

  task automatic test_async_clear();
    int dcnt;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; count = 3'd4; fill = 1'b0; data_in = 4'b1011;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (ser_valid !== 1'b1) begin
      fails++;
      $display("FAIL clear_pre: ser_valid=%b expected 1", ser_valid);
    end
    #2 clear = 1'b1;
    #1;
    tests++;
    if ({s1, s0, i_par, msb_in, lsb_in, busy, done, ser_valid} !== 11'd0) begin
      fails++;
      $display("FAIL clear_async: got %b expected 0", {s1, s0, i_par, msb_in, lsb_in, busy, done, ser_valid});
    end
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (a_par !== exp_apar(4'b1011, 1'b0, 1'b0, 1)) begin
      fails++;
      $display("FAIL clear_partial: a_par=%b expected %b", a_par, exp_apar(4'b1011, 1'b0, 1'b0, 1));
    end
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    tests++;
    if (dcnt != 0) begin
      fails++;
      $display("FAIL clear_no_done: active cycles=%0d expected 0", dcnt);
    end
    run_seq("after_clear", 4'b1011, 1'b0, 3'd4, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_seq("random", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_a", 4'b1001, 1'b1, 3'd3, 1'b1, 1'b0);
    run_seq("b2b_b", 4'b0110, 1'b0, 3'd1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    run_seq("right_full", 4'b1011, 1'b0, 3'd4, 1'b0, 1'b0);
    run_seq("left_fill", 4'b1011, 1'b1, 3'd2, 1'b1, 1'b0);
    run_seq("load_only", 4'b0110, 1'b0, 3'd0, 1'b0, 1'b0);
    run_seq("ignored_start", 4'b1100, 1'b0, 3'd4, 1'b1, 1'b1);
    test_async_clear();
    run_seq("overlong", 4'b1111, 1'b0, 3'd7, 1'b0, 1'b0);
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer_4.md
# shift_sequencer_4

Control stage that sits directly upstream of the 4-bit universal shift register and drives its mode selects, parallel input and serial fill inputs. On a start request it loads a nibble into the register, runs a programmed number of right or left shifts, and presents each bit leaving the register as a serial output. It then holds the register and pulses done. It replaces hand-toggled s1/s0 stimulus with a deterministic load/shift/hold sequence.

## Interface
- CNT_W, 3, width of the shift-count input (0 to 2^CNT_W-1 shifts)
- clk  in  1  single clock; all state changes on rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  request a sequence; sampled only in IDLE
- dir  in  1  0 = shift right (toward bit 0), 1 = shift left (toward bit 3)
- count  in  CNT_W  number of shift cycles after the load
- fill  in  1  serial bit injected on each shift
- data_in  in  4  nibble to parallel-load
- a_par  in  4  current register contents (fed back from the register)
- s1, s0  out  1 each  register mode: 00 hold, 01 shift right (msb_in enters bit 3), 10 shift left (lsb_in enters bit 0), 11 parallel load
- i_par  out  4  parallel-load value to the register
- msb_in, lsb_in  out  1 each  serial inputs to the register
- ser_out  out  1  bit leaving the register on the coming edge
- ser_valid  out  1  ser_out is meaningful this cycle
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- The registered state variable drives every register-facing output; the register samples these outputs on the following rising edge.
- IDLE:
  - Outputs: s1s0=00, busy=0.
  - If start=1 at an edge: latch dir, count, fill and data_in into internal registers, then go to LOAD.
- LOAD:
  - Outputs: s1s0=11, i_par=latched data, busy=1.
  - Next state: SHIFT if latched count>0, else DONE.
  - Initialise a remaining-shift counter to count.
- SHIFT:
  - s1s0=01 if dir=0, 10 if dir=1.
  - dir=0: msb_in=fill, lsb_in=0. dir=1: lsb_in=fill, msb_in=0.
  - The counter decrements each cycle. When it reaches 1, go to DONE on the next edge. Exactly count shift cycles occur.
- DONE:
  - Outputs: s1s0=00, done=1, busy=1.
  - Go to IDLE unconditionally.
- ser_out (combinational from a_par): a_par[0] when dir=0, a_par[3] when dir=1. ser_valid=1 only in SHIFT, else 0.
- i_par holds the latched data in all states; it is 0 after reset.
- Outside SHIFT, msb_in and lsb_in are 0.
- start asserted in any state other than IDLE is ignored; it is not queued.
- count greater than 4 is legal: the register fills entirely with fill, and ser_out then repeats fill.
- Inputs are re-latched only on the IDLE→LOAD transition. Changes to inputs mid-sequence have no effect.

## Timing
- clear=1 forces the following regardless of clk: state=IDLE, s1=s0=0, i_par=0000, msb_in=lsb_in=0, busy=0, done=0, ser_valid=0.
- Deasserting clear gives IDLE on the next edge behaviour.
- clear mid-sequence aborts the sequence: no done pulse, and the register is left holding its partial contents.
- Start sampled at edge E0:
  - LOAD occupies cycle E0–E1; the register loads at E1.
  - SHIFT occupies cycles E1 through E(count); the register shifts at E2 through E(count+1).
  - DONE occupies cycle E(count+1)–E(count+2).
  - IDLE resumes from E(count+2).
- busy is high for count+2 cycles; done is high for exactly one cycle.
- Latency from start edge to done rising: count+1 edges.
- A new start may be sampled at the same edge at which DONE returns to IDLE + 1, i.e. the first IDLE edge. Back-to-back sequences are separated by one IDLE cycle minimum.
- ser_out is valid for the whole SHIFT cycle and refers to the bit the register discards at that cycle's closing edge.

## Test plan
- Right shift, full: data_in=1011, dir=0, count=4, fill=0 → ser_out sequence 1,1,0,1 with ser_valid high for 4 cycles. a_par=0000 after done. done 5 edges after start.
- Left shift, partial with fill: data_in=1011, dir=1, count=2, fill=1 → ser_out 1,0. a_par goes 1011→0111→1111 and holds 1111 after done.
- Load only: data_in=0110, count=0 → LOAD then DONE. a_par=0110. ser_valid never high. busy for 2 cycles.
- Ignored start: pulse start again during SHIFT of a count=4 run → sequence length unchanged, exactly one done pulse, IDLE afterwards.
- Async clear mid-shift: assert clear between edges in the 2nd SHIFT cycle → outputs zero immediately without a clock edge. No done pulse. A fresh start after release runs a normal full sequence.
- Overlong count: data_in=1111, dir=0, count=7, fill=0 → ser_out 1,1,1,1,0,0,0. a_par=0000. done after 8 edges.
